// File: rtl/cvrisc.sv
// CVRISC: small RV32I system with 8 KiB RAM, three 8-bit PWM channels and a UART
// whose receive stream also drives a debug loader able to write/read RAM and halt the CPU.
module cvrisc #(
    parameter int F_CLK = 12000000,
    parameter int BAUD  = 115200
) (
    input  logic CLK,
    input  logic RESET,
    input  logic PICO_UART0_RX,
    output logic PICO_UART0_TX,
    output logic PWM0,
    output logic PWM1,
    output logic PWM2
);
    localparam int BIT_CLKS  = F_CLK / BAUD;
    localparam int HALF_CLKS = BIT_CLKS / 2;

    logic        cpu_valid, cpu_ready, cpu_n_reset, loader_run;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic [3:0]  cpu_wstrb;
    logic        dbg_mem_op;
    logic [3:0]  dbg_wren;
    logic [31:0] dbg_adr, dbg_do;

    assign cpu_n_reset = RESET & loader_run;

    cvrisc_core #(.RESET_PC(32'h0002_0000)) u_core (
        .clk(CLK), .resetn(cpu_n_reset), .valid(cpu_valid), .addr(cpu_addr),
        .wdata(cpu_wdata), .wstrb(cpu_wstrb), .rdata(cpu_rdata), .ready(cpu_ready)
    );

    // ---------------- bus, RAM, PWM ----------------
    logic        ack, svc, sel_pwm, sel_uart, cpu_rx_rd, cpu_tx_wr;
    logic [1:0]  sel_q;
    logic [31:0] per_q, ram_q, ram_wd;
    logic [10:0] ram_idx;
    logic [3:0]  ram_we;
    logic [31:0] ram [0:2047];
    logic [7:0]  pwm_cmp [0:2];
    logic [7:0]  pwm_cnt;
    logic        tx_busy, rx_valid;
    logic [7:0]  rx_data;

    // A debug access steals the cycle; the CPU request is serviced the cycle after.
    assign svc       = cpu_valid && !ack && !dbg_mem_op;
    assign sel_pwm   = cpu_addr[17:16] == 2'b01;
    assign sel_uart  = cpu_addr[17:16] == 2'b11;
    assign cpu_rx_rd = svc && sel_uart && cpu_addr[15:2] == 14'd1 && cpu_wstrb == 4'h0;
    assign cpu_tx_wr = svc && sel_uart && cpu_addr[15:2] == 14'd0 && cpu_wstrb[0];
    assign cpu_ready = ack;
    assign cpu_rdata = (sel_q == 2'b10) ? ram_q : per_q;

    always_comb begin
        ram_idx = cpu_addr[12:2];
        ram_wd  = cpu_wdata;
        ram_we  = (svc && cpu_addr[17:16] == 2'b10) ? cpu_wstrb : 4'h0;
        if (dbg_mem_op) begin
            ram_idx = dbg_adr[12:2];
            ram_wd  = dbg_do;
            ram_we  = dbg_wren;
        end
    end

    always_ff @(posedge CLK) begin
        for (int i = 0; i < 4; i++)
            if (ram_we[i]) ram[ram_idx][8*i +: 8] <= ram_wd[8*i +: 8];
        ram_q <= ram[ram_idx];
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ack     <= 1'b0;
            sel_q   <= 2'b00;
            per_q   <= 32'd0;
            pwm_cnt <= 8'd0;
            PWM0    <= 1'b0;
            PWM1    <= 1'b0;
            PWM2    <= 1'b0;
            for (int i = 0; i < 3; i++) pwm_cmp[i] <= 8'h80;
        end else begin
            ack     <= svc;
            pwm_cnt <= pwm_cnt + 8'd1;
            PWM0    <= pwm_cnt < pwm_cmp[0];
            PWM1    <= pwm_cnt < pwm_cmp[1];
            PWM2    <= pwm_cnt < pwm_cmp[2];
            if (svc) begin
                sel_q <= cpu_addr[17:16];
                per_q <= 32'd0;
                if (sel_pwm)
                    for (int i = 0; i < 3; i++)
                        if (cpu_addr[15:2] == 14'(i)) begin
                            per_q <= {24'd0, pwm_cmp[i]};
                            if (cpu_wstrb[0]) pwm_cmp[i] <= cpu_wdata[7:0];
                        end
                if (sel_uart && cpu_addr[15:2] == 14'd0) per_q <= {30'd0, rx_valid, tx_busy};
                if (sel_uart && cpu_addr[15:2] == 14'd1) per_q <= {24'd0, rx_data};
            end
        end
    end

    // ---------------- UART receiver ----------------
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    rx_state_t   r_state;
    logic [1:0]  rx_sync;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit;
    logic [7:0]  r_sh, rx_byte;
    logic        r_drop, rx_done, rx_pend, rx_s;

    assign rx_s = rx_sync[1];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            rx_sync <= 2'b11;
            r_state <= R_IDLE;
            r_cnt   <= 16'd0;
            r_bit   <= 3'd0;
            r_sh    <= 8'd0;
            r_drop  <= 1'b0;
            rx_done <= 1'b0;
            rx_byte <= 8'd0;
        end else begin
            rx_sync <= {rx_sync[0], PICO_UART0_RX};
            rx_done <= 1'b0;
            case (r_state)
                R_IDLE: if (!rx_s) begin r_cnt <= 16'd0; r_state <= R_START; end
                R_START: begin
                    if (rx_s) r_state <= R_IDLE;  // glitch shorter than half a bit
                    else if (r_cnt == 16'(HALF_CLKS - 1)) begin
                        r_cnt <= 16'd0; r_bit <= 3'd0; r_drop <= rx_pend; r_state <= R_DATA;
                    end else r_cnt <= r_cnt + 16'd1;
                end
                R_DATA: begin
                    if (r_cnt == 16'(BIT_CLKS - 1)) begin
                        r_cnt <= 16'd0;
                        r_sh  <= {rx_s, r_sh[7:1]};
                        if (r_bit == 3'd7) r_state <= R_STOP;
                        else r_bit <= r_bit + 3'd1;
                    end else r_cnt <= r_cnt + 16'd1;
                end
                default: begin
                    if (r_cnt == 16'(BIT_CLKS - 1)) begin
                        r_state <= R_IDLE;
                        if (rx_s && !r_drop && !rx_pend) begin rx_byte <= r_sh; rx_done <= 1'b1; end
                    end else r_cnt <= r_cnt + 16'd1;
                end
            endcase
        end
    end

    // ---------------- debug loader ----------------
    typedef enum logic [2:0] {L_IDLE, L_ADDR, L_DATA, L_EXEC, L_REPLY} ld_state_t;
    ld_state_t   ld_state;
    logic        ld_write, ld_fetch, ld_take, ld_tx_go;
    logic [1:0]  ld_cnt;
    logic [31:0] ld_adr, ld_dat;

    assign ld_take    = rx_pend && (ld_state == L_IDLE || ld_state == L_ADDR || ld_state == L_DATA);
    assign ld_tx_go   = ld_state == L_REPLY && !ld_fetch && !tx_busy;
    assign dbg_mem_op = ld_state == L_EXEC;
    assign dbg_wren   = ld_write ? 4'hF : 4'h0;
    assign dbg_adr    = ld_adr;
    assign dbg_do     = ld_dat;

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            ld_state   <= L_IDLE;
            loader_run <= 1'b1;
            ld_write   <= 1'b0;
            ld_fetch   <= 1'b0;
            ld_cnt     <= 2'd0;
            ld_adr     <= 32'd0;
            ld_dat     <= 32'd0;
            rx_pend    <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= 8'd0;
        end else begin
            if (rx_done) rx_pend <= 1'b1;
            if (ld_take) rx_pend <= 1'b0;
            if (cpu_rx_rd) rx_valid <= 1'b0;
            case (ld_state)
                L_IDLE: if (ld_take) begin
                    ld_cnt <= 2'd0;
                    case (rx_byte)
                        "W": begin ld_write <= 1'b1; ld_state <= L_ADDR; end
                        "R": begin ld_write <= 1'b0; ld_state <= L_ADDR; end
                        "H": loader_run <= 1'b0;
                        "G": loader_run <= 1'b1;
                        default: begin rx_data <= rx_byte; rx_valid <= 1'b1; end
                    endcase
                end
                L_ADDR: if (ld_take) begin
                    ld_adr <= {rx_byte, ld_adr[31:8]};
                    ld_cnt <= ld_cnt + 2'd1;
                    if (ld_cnt == 2'd3) ld_state <= ld_write ? L_DATA : L_EXEC;
                end
                L_DATA: if (ld_take) begin
                    ld_dat <= {rx_byte, ld_dat[31:8]};
                    ld_cnt <= ld_cnt + 2'd1;
                    if (ld_cnt == 2'd3) ld_state <= L_EXEC;
                end
                L_EXEC: begin
                    ld_fetch <= !ld_write;
                    ld_cnt   <= 2'd0;
                    ld_state <= ld_write ? L_IDLE : L_REPLY;
                end
                L_REPLY: begin
                    if (ld_fetch) begin
                        ld_dat   <= ram_q;
                        ld_fetch <= 1'b0;
                    end else if (!tx_busy) begin
                        ld_dat <= {8'd0, ld_dat[31:8]};
                        ld_cnt <= ld_cnt + 2'd1;
                        if (ld_cnt == 2'd3) ld_state <= L_IDLE;
                    end
                end
                default: ld_state <= L_IDLE;
            endcase
        end
    end

    // ---------------- UART transmitter (loader wins, busy drops CPU bytes) ----------------
    logic [15:0] t_cnt;
    logic [3:0]  t_bit;
    logic [9:0]  t_sh;
    logic [7:0]  tx_din;

    assign tx_din = ld_tx_go ? ld_dat[7:0] : cpu_wdata[7:0];

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            PICO_UART0_TX <= 1'b1;
            tx_busy       <= 1'b0;
            t_cnt         <= 16'd0;
            t_bit         <= 4'd0;
            t_sh          <= 10'h3FF;
        end else if (!tx_busy) begin
            PICO_UART0_TX <= 1'b1;
            if (ld_tx_go || cpu_tx_wr) begin
                t_sh          <= {1'b1, tx_din, 1'b0};
                tx_busy       <= 1'b1;
                t_cnt         <= 16'd0;
                t_bit         <= 4'd0;
                PICO_UART0_TX <= 1'b0;
            end
        end else if (t_cnt == 16'(BIT_CLKS - 1)) begin
            t_cnt <= 16'd0;
            if (t_bit == 4'd9) begin
                tx_busy       <= 1'b0;
                PICO_UART0_TX <= 1'b1;
            end else begin
                t_bit         <= t_bit + 4'd1;
                t_sh          <= {1'b1, t_sh[9:1]};
                PICO_UART0_TX <= t_sh[1];
            end
        end else t_cnt <= t_cnt + 16'd1;
    end
endmodule

// Minimal multicycle RV32I core: fetch, execute, optional memory phase.
module cvrisc_core #(
    parameter logic [31:0] RESET_PC = 32'h0002_0000
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        valid,
    output logic [31:0] addr,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic [31:0] rdata,
    input  logic        ready
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;

    typedef enum logic [1:0] {C_FETCH, C_EXEC, C_MEM} core_state_t;
    core_state_t state;
    logic [31:0] pc, ir, ea, st_data;
    logic [3:0]  st_strb;
    logic [31:0] rf [0:31];
    logic [6:0]  opc;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [31:0] a, b, op_b, alu, imm_i, imm_s, imm_b, imm_u, imm_j, ea_next, sh, ld_val, wb_val;
    logic        take, wb_en;

    assign opc   = ir[6:0];
    assign rd    = ir[11:7];
    assign f3    = ir[14:12];
    assign rs1   = ir[19:15];
    assign rs2   = ir[24:20];
    assign imm_i = {{20{ir[31]}}, ir[31:20]};
    assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
    assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    assign imm_u = {ir[31:12], 12'd0};
    assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
    assign a     = (rs1 == 5'd0) ? 32'd0 : rf[rs1];
    assign b     = (rs2 == 5'd0) ? 32'd0 : rf[rs2];
    assign op_b  = (opc == OP_REG) ? b : imm_i;
    assign ea_next = a + ((opc == OP_STORE) ? imm_s : imm_i);
    assign sh    = rdata >> {ea[1:0], 3'b000};

    assign valid = resetn && state != C_EXEC;
    assign addr  = (state == C_FETCH) ? pc : ea;
    assign wdata = st_data;
    assign wstrb = (state == C_MEM && opc == OP_STORE) ? st_strb : 4'h0;

    always_comb begin
        case (f3)
            3'd0: alu = (opc == OP_REG && ir[30]) ? a - op_b : a + op_b;
            3'd1: alu = a << op_b[4:0];
            3'd2: alu = {31'd0, $signed(a) < $signed(op_b)};
            3'd3: alu = {31'd0, a < op_b};
            3'd4: alu = a ^ op_b;
            3'd5: alu = ir[30] ? $signed(a) >>> op_b[4:0] : a >> op_b[4:0];
            3'd6: alu = a | op_b;
            default: alu = a & op_b;
        endcase
        case (f3)
            3'd0: take = a == b;
            3'd1: take = a != b;
            3'd4: take = $signed(a) < $signed(b);
            3'd5: take = $signed(a) >= $signed(b);
            3'd6: take = a < b;
            3'd7: take = a >= b;
            default: take = 1'b0;
        endcase
        case (f3)
            3'd0: ld_val = {{24{sh[7]}}, sh[7:0]};
            3'd1: ld_val = {{16{sh[15]}}, sh[15:0]};
            3'd4: ld_val = {24'd0, sh[7:0]};
            3'd5: ld_val = {16'd0, sh[15:0]};
            default: ld_val = sh;
        endcase
        wb_en  = 1'b0;
        wb_val = alu;
        if (state == C_EXEC) begin
            case (opc)
                OP_LUI:          begin wb_en = 1'b1; wb_val = imm_u; end
                OP_AUIPC:        begin wb_en = 1'b1; wb_val = pc + imm_u; end
                OP_JAL, OP_JALR: begin wb_en = 1'b1; wb_val = pc + 32'd4; end
                OP_IMM, OP_REG:  wb_en = 1'b1;
                default:         wb_en = 1'b0;
            endcase
        end else if (state == C_MEM && ready && opc == OP_LOAD) begin
            wb_en  = 1'b1;
            wb_val = ld_val;
        end
    end

    always_ff @(posedge clk)
        if (resetn && wb_en && rd != 5'd0) rf[rd] <= wb_val;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state   <= C_FETCH;
            pc      <= RESET_PC;
            ir      <= 32'd0;
            ea      <= 32'd0;
            st_data <= 32'd0;
            st_strb <= 4'h0;
        end else begin
            case (state)
                C_FETCH: if (ready) begin ir <= rdata; state <= C_EXEC; end
                C_EXEC: begin
                    state   <= C_FETCH;
                    pc      <= pc + 32'd4;
                    ea      <= ea_next;
                    st_data <= b << {ea_next[1:0], 3'b000};
                    case (f3[1:0])
                        2'd0:    st_strb <= 4'b0001 << ea_next[1:0];
                        2'd1:    st_strb <= 4'b0011 << ea_next[1:0];
                        default: st_strb <= 4'hF;
                    endcase
                    case (opc)
                        OP_JAL:            pc <= pc + imm_j;
                        OP_JALR:           pc <= (a + imm_i) & ~32'd1;
                        OP_BR:             if (take) pc <= pc + imm_b;
                        OP_LOAD, OP_STORE: begin pc <= pc; state <= C_MEM; end
                        default: ;
                    endcase
                end
                C_MEM: if (ready) begin pc <= pc + 32'd4; state <= C_FETCH; end
                default: state <= C_FETCH;
            endcase
        end
    end
endmodule

// File: tb/tb_cvrisc.sv
// Directed bench for cvrisc: drives the debug loader over UART and checks PWM duty and TX replies.
module tb_cvrisc;
    localparam int F_CLK = 1_600_000;
    localparam int BAUD  = 100_000;
    localparam int BIT   = F_CLK / BAUD;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic rx = 1'b1;
    logic tx, pwm0, pwm1, pwm2;
    int   n_vec = 0;
    int   n_err = 0;

    cvrisc #(.F_CLK(F_CLK), .BAUD(BAUD)) dut (
        .CLK(clk), .RESET(reset_n), .PICO_UART0_RX(rx), .PICO_UART0_TX(tx),
        .PWM0(pwm0), .PWM1(pwm1), .PWM2(pwm2)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] v);
        rx = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = v[i];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
        repeat (BIT + 4) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
    endtask

    task automatic recv_byte(output logic [7:0] v, output bit ok);
        int t;
        t = 0; ok = 1'b0; v = 8'd0;
        while (tx === 1'b1 && t < 3000) begin @(negedge clk); t++; end
        if (tx !== 1'b0) return;
        repeat (BIT / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (BIT) @(negedge clk);
            v[i] = tx;
        end
        repeat (BIT) @(negedge clk);
        ok = (tx === 1'b1);
    endtask

    task automatic recv_word(output logic [31:0] w, output logic [3:0] ok);
        logic [7:0] v;
        bit k;
        w = 32'd0; ok = 4'h0;
        for (int i = 0; i < 4; i++) begin
            recv_byte(v, k);
            w[8*i +: 8] = v;
            ok[i] = k;
            if (!k) break;
        end
    endtask

    task automatic cmd_write(input logic [31:0] adr, input logic [31:0] dat);
        send_byte("W");
        send_word(adr);
        send_word(dat);
        repeat (4) @(negedge clk);
    endtask

    task automatic cmd_read_check(input string tag, input logic [31:0] adr,
                                  input logic [31:0] exp, input bit glitch);
        logic [31:0] got;
        logic [3:0]  ok;
        fork
            begin
                send_byte("R");
                if (glitch) begin
                    rx = 1'b0;
                    repeat (BIT / 4) @(negedge clk);
                    rx = 1'b1;
                    repeat (BIT) @(negedge clk);
                end
                send_word(adr);
            end
            recv_word(got, ok);
        join
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("%s_b%0d", tag, i), {23'd0, ok[i], got[8*i +: 8]},
                     {23'd0, 1'b1, exp[8*i +: 8]});
    endtask

    task automatic duty_check(input string tag, input int exp_high);
        int h0, h1, h2;
        h0 = 0; h1 = 0; h2 = 0;
        repeat (256) begin
            @(negedge clk);
            h0 += int'(pwm0);
            h1 += int'(pwm1);
            h2 += int'(pwm2);
        end
        check_eq({tag, "_pwm0"}, h0, exp_high);
        check_eq({tag, "_pwm1"}, h1, exp_high);
        check_eq({tag, "_pwm2"}, h2, exp_high);
    endtask

    task automatic reset_outputs_check(input string tag);
        check_eq({tag, "_pwm0"}, {31'd0, pwm0}, 32'd0);
        check_eq({tag, "_pwm1"}, {31'd0, pwm1}, 32'd0);
        check_eq({tag, "_pwm2"}, {31'd0, pwm2}, 32'd0);
        check_eq({tag, "_tx"},   {31'd0, tx},   32'd1);
    endtask

    initial begin
        int t;
        reset_n = 1'b0;
        rx = 1'b1;
        repeat (4) @(negedge clk);
        reset_outputs_check("por");

        // Halt the CPU so RAM/PWM are only touched through the loader.
        reset_n = 1'b1;
        send_byte("H");
        repeat (20) @(negedge clk);
        duty_check("duty_default", 128);

        // Reset while PWM0 is high must drop it on the next edge.
        t = 0;
        while (pwm0 !== 1'b1 && t < 600) begin @(negedge clk); t++; end
        check_eq("pwm0_seen_high", {31'd0, pwm0}, 32'd1);
        reset_n = 1'b0;
        @(negedge clk);
        reset_outputs_check("rst_high");
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        send_byte("H");
        repeat (20) @(negedge clk);

        cmd_write(32'h0002_0000, 32'h1234_5678);
        cmd_read_check("rd_ram", 32'h0002_0000, 32'h1234_5678, 1'b0);

        cmd_write(32'h0002_0000, 32'h0001_07b7);
        cmd_write(32'h0002_0004, 32'h0007_a023);
        cmd_write(32'h0002_0008, 32'h0007_a223);
        cmd_write(32'h0002_000c, 32'h0007_a423);
        cmd_write(32'h0002_0010, 32'h0000_006f);
        cmd_read_check("rd_glitch", 32'h0002_0004, 32'h0007_a023, 1'b1);
        duty_check("duty_halted", 128);

        send_byte("G");
        repeat (300) @(negedge clk);
        duty_check("duty_prog", 0);

        // Mid-program reset: outputs to reset values, RAM kept, program runs again.
        reset_n = 1'b0;
        @(negedge clk);
        reset_outputs_check("rst_mid");
        repeat (5) @(negedge clk);
        reset_n = 1'b1;
        repeat (300) @(negedge clk);
        duty_check("duty_rerun", 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
